// File: rtl/vic_irq_source.sv
// vic_irq_source: interrupt-source side of the VIC handshake.
// Latches rising edges on peripheral lines as pending, masks them, picks the
// lowest enabled index and pulses it into the controller, keeping one interrupt
// in flight at a time. Supports tail-chaining on reti and re-pulsing when the
// controller fails to acknowledge within ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_src_irq       peripheral request lines (rising-edge sensitive)
//   i_mask_we       enable-mask write strobe
//   i_mask_wdata    new enable mask, 1 = source enabled
//   i_in_service    controller flag: ISR executing
//   i_reti          return-from-interrupt pulse from the core
//   o_IRQ           one-cycle request pulse to the controller
//   o_ISR_addr      index of the dispatched source
//   o_pending       latched pending bits (unmasked view)
//   o_busy          high whenever the FSM is not idle
//   o_chain         high with o_IRQ when the dispatch is a tail-chain
module vic_irq_source #(
    parameter int unsigned N_SRC       = 32,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter bit          TAIL_CHAIN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] i_src_irq,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_wdata,
    input  logic             i_in_service,
    input  logic             i_reti,
    output logic             o_IRQ,
    output logic [4:0]       o_ISR_addr,
    output logic [N_SRC-1:0] o_pending,
    output logic             o_busy,
    output logic             o_chain
);

    localparam int unsigned TW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StRetry,
        StService
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [4:0]       act_id_q, act_id_d;
    logic             irq_q, irq_d;
    logic [4:0]       addr_q, addr_d;
    logic             chain_q, chain_d;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] sel_oh;
    logic [N_SRC-1:0] edge_set;
    logic [4:0]       sel;
    logic             any_req;

    assign req      = pend_q & mask_q;
    assign any_req  = |req;
    assign edge_set = i_src_irq & ~prev_q;

    // Lowest index wins; scan downwards so the last hit is the winner.
    always_comb begin
        sel    = '0;
        sel_oh = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                sel       = 5'(k);
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = i_src_irq;
        mask_d   = i_mask_we ? i_mask_wdata : mask_q;
        timer_d  = timer_q;
        act_id_d = act_id_q;
        irq_d    = 1'b0;
        addr_d   = addr_q;
        chain_d  = 1'b0;
        pend_d   = pend_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (i_in_service) begin
                    state_d = StService;
                end else if (timer_q == TW'(ACK_TIMEOUT)) begin
                    state_d = StRetry;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRetry: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StService: begin
                if (i_reti && TAIL_CHAIN && any_req) begin
                    state_d = StAssert;
                    chain_d = 1'b1;
                end else if (i_reti || !i_in_service) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Dispatch happens on the transition into StAssert so that the pulse,
        // the address and the pending clear all line up in the same cycle.
        if (state_d == StAssert) begin
            irq_d    = 1'b1;
            addr_d   = sel;
            act_id_d = sel;
            pend_d   = pend_q & ~sel_oh;
        end else if (state_d == StRetry) begin
            irq_d  = 1'b1;
            addr_d = act_id_q;
        end

        // A fresh edge beats a same-cycle dispatch clear.
        pend_d = pend_d | edge_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            prev_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '1;
            timer_q  <= '0;
            act_id_q <= '0;
            irq_q    <= 1'b0;
            addr_q   <= '0;
            chain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
            act_id_q <= act_id_d;
            irq_q    <= irq_d;
            addr_q   <= addr_d;
            chain_q  <= chain_d;
        end
    end

    assign o_IRQ      = irq_q;
    assign o_ISR_addr = addr_q;
    assign o_pending  = pend_q;
    assign o_busy     = (state_q != StIdle);
    assign o_chain    = chain_q;

endmodule

// File: tb/tb_vic_irq_source.sv
module tb_vic_irq_source;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_src_irq;
    logic        i_mask_we;
    logic [31:0] i_mask_wdata;
    logic        i_in_service;
    logic        i_reti;
    logic        o_IRQ;
    logic [4:0]  o_ISR_addr;
    logic [31:0] o_pending;
    logic        o_busy;
    logic        o_chain;

    int n_cmp = 0;
    int n_err = 0;

    // Expected dispatches: {chain, addr}
    logic [5:0] exp_q[$];

    vic_irq_source #(
        .N_SRC      (32),
        .ACK_TIMEOUT(15),
        .TAIL_CHAIN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_src_irq   (i_src_irq),
        .i_mask_we   (i_mask_we),
        .i_mask_wdata(i_mask_wdata),
        .i_in_service(i_in_service),
        .i_reti      (i_reti),
        .o_IRQ       (o_IRQ),
        .o_ISR_addr  (o_ISR_addr),
        .o_pending   (o_pending),
        .o_busy      (o_busy),
        .o_chain     (o_chain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every IRQ pulse must match the next queued dispatch.
    always @(negedge clk) begin
        if (!rst && o_IRQ === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_irq", {26'd0, o_chain, o_ISR_addr}, 32'h3f);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("sb_dispatch", {26'd0, o_chain, o_ISR_addr}, {26'd0, e});
            end
        end
    end

    // Acknowledge the in-flight interrupt and return from it.
    task automatic serve();
        i_in_service = 1'b1;
        cyc(1);
        i_reti = 1'b1;
        cyc(1);
        i_reti = 1'b0;
        i_in_service = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        i_src_irq    = '0;
        i_mask_we    = 1'b0;
        i_mask_wdata = '0;
        i_in_service = 1'b0;
        i_reti       = 1'b0;
        cyc(3);
        chk("rst_irq", {31'd0, o_IRQ}, 32'd0);
        chk("rst_addr", {27'd0, o_ISR_addr}, 32'd0);
        chk("rst_pend", o_pending, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_chain", {31'd0, o_chain}, 32'd0);
        rst = 1'b0;
        cyc(1);

        // Single source on line 5, two-cycle latency.
        exp_q.push_back({1'b0, 5'd5});
        i_src_irq = 32'h1 << 5;
        cyc(1);
        i_src_irq = '0;
        chk("s_lat_irq", {31'd0, o_IRQ}, 32'd0);
        chk("s_pend_set", o_pending, 32'h1 << 5);
        cyc(1);
        chk("s_irq", {31'd0, o_IRQ}, 32'd1);
        chk("s_addr", {27'd0, o_ISR_addr}, 32'd5);
        chk("s_pend_clr", o_pending, 32'd0);
        chk("s_busy", {31'd0, o_busy}, 32'd1);
        cyc(1);
        chk("s_width", {31'd0, o_IRQ}, 32'd0);
        serve();
        chk("s_idle", {31'd0, o_busy}, 32'd0);

        // Priority with tail-chain.
        exp_q.push_back({1'b0, 5'd3});
        exp_q.push_back({1'b1, 5'd9});
        i_src_irq = (32'h1 << 9) | (32'h1 << 3);
        cyc(1);
        i_src_irq = '0;
        cyc(1);
        chk("p_addr", {27'd0, o_ISR_addr}, 32'd3);
        chk("p_pend9", o_pending, 32'h1 << 9);
        cyc(1);
        i_in_service = 1'b1;
        cyc(1);
        i_reti = 1'b1;
        cyc(1);
        i_reti = 1'b0;
        i_in_service = 1'b0;
        chk("p_chain_irq", {31'd0, o_IRQ}, 32'd1);
        chk("p_chain_addr", {27'd0, o_ISR_addr}, 32'd9);
        chk("p_chain_flag", {31'd0, o_chain}, 32'd1);
        cyc(1);
        serve();
        chk("p_idle", {31'd0, o_busy}, 32'd0);

        // Masked source stays pending until enabled.
        i_mask_we = 1'b1;
        i_mask_wdata = ~(32'h1 << 4);
        cyc(1);
        i_mask_we = 1'b0;
        i_src_irq = 32'h1 << 4;
        cyc(1);
        i_src_irq = '0;
        cyc(3);
        chk("m_no_irq", {31'd0, o_IRQ}, 32'd0);
        chk("m_pend", o_pending, 32'h1 << 4);
        chk("m_idle", {31'd0, o_busy}, 32'd0);
        exp_q.push_back({1'b0, 5'd4});
        i_mask_we = 1'b1;
        i_mask_wdata = '1;
        cyc(1);
        i_mask_we = 1'b0;
        cyc(1);
        chk("m_irq", {31'd0, o_IRQ}, 32'd1);
        chk("m_addr", {27'd0, o_ISR_addr}, 32'd4);
        cyc(1);
        serve();

        // Ack timeout: re-pulse every 17 cycles.
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 5'd7});
        i_src_irq = 32'h1 << 7;
        cyc(1);
        i_src_irq = '0;
        cyc(1);
        chk("t_first", {31'd0, o_IRQ}, 32'd1);
        for (int r = 0; r < 2; r++) begin
            cyc(16);
            chk("t_gap", {31'd0, o_IRQ}, 32'd0);
            cyc(1);
            chk("t_retry", {31'd0, o_IRQ}, 32'd1);
            chk("t_addr", {27'd0, o_ISR_addr}, 32'd7);
        end
        cyc(1);
        i_in_service = 1'b1;
        cyc(20);
        chk("t_held_busy", {31'd0, o_busy}, 32'd1);
        chk("t_held_noirq", {31'd0, o_IRQ}, 32'd0);
        i_reti = 1'b1;
        cyc(1);
        i_reti = 1'b0;
        i_in_service = 1'b0;
        chk("t_idle", {31'd0, o_busy}, 32'd0);

        // Set/clear collision on line 2.
        i_mask_we = 1'b1;
        i_mask_wdata = ~(32'h1 << 2);
        cyc(1);
        i_mask_we = 1'b0;
        i_src_irq = 32'h1 << 2;
        cyc(1);
        i_src_irq = '0;
        cyc(1);
        exp_q.push_back({1'b0, 5'd2});
        exp_q.push_back({1'b1, 5'd2});
        i_mask_we = 1'b1;
        i_mask_wdata = '1;
        cyc(1);
        i_mask_we = 1'b0;
        i_src_irq = 32'h1 << 2;
        cyc(1);
        i_src_irq = '0;
        chk("c_irq", {31'd0, o_IRQ}, 32'd1);
        chk("c_pend_kept", o_pending, 32'h1 << 2);
        cyc(1);
        i_in_service = 1'b1;
        cyc(1);
        i_reti = 1'b1;
        cyc(1);
        i_reti = 1'b0;
        i_in_service = 1'b0;
        chk("c_second", {31'd0, o_IRQ}, 32'd1);
        chk("c_pend_done", o_pending, 32'd0);
        cyc(1);
        serve();

        // Reset while in service drops pending work.
        exp_q.push_back({1'b0, 5'd1});
        i_src_irq = (32'h1 << 1) | (32'h1 << 6);
        cyc(1);
        i_src_irq = '0;
        cyc(1);
        chk("r_addr", {27'd0, o_ISR_addr}, 32'd1);
        chk("r_pend6", o_pending, 32'h1 << 6);
        cyc(1);
        i_in_service = 1'b1;
        cyc(1);
        chk("r_service", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        i_in_service = 1'b0;
        chk("r_busy", {31'd0, o_busy}, 32'd0);
        chk("r_pend", o_pending, 32'd0);
        chk("r_irq", {31'd0, o_IRQ}, 32'd0);
        cyc(10);
        chk("r_quiet", {31'd0, o_busy}, 32'd0);
        exp_q.push_back({1'b0, 5'd6});
        i_src_irq = 32'h1 << 6;
        cyc(1);
        i_src_irq = '0;
        cyc(1);
        chk("r_new_irq", {31'd0, o_IRQ}, 32'd1);
        chk("r_new_addr", {27'd0, o_ISR_addr}, 32'd6);
        cyc(1);
        serve();
        cyc(2);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vic_irq_source.md
Name: vic_irq_source

Overview:
- Interrupt-source side of the VIC handshake.
- Collects peripheral interrupt lines, latches them as pending, applies an enable mask and priority-encodes them.
- Drives the single-cycle IRQ pulse and 5-bit ISR index into the VIC controller.
- Tracks the controller's in-service flag and reti, so only one interrupt is in flight at a time; supports tail-chaining and ack-timeout retry.

Parameters:
- N_SRC, 32, number of peripheral lines; legal range 1..32.
- ACK_TIMEOUT, 15, cycles to wait for i_in_service after a pulse before re-pulsing.
- TAIL_CHAIN, 1, 1 = dispatch next pending directly on reti; 0 = return to IDLE first.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_src_irq  in  N_SRC  peripheral requests, rising-edge sensitive.
- i_mask_we  in  1  enable-mask write strobe.
- i_mask_wdata  in  N_SRC  new enable mask; bit=1 enables the source.
- i_in_service  in  1  controller's IRQ_VIC flag (ISR executing).
- i_reti  in  1  return-from-interrupt pulse from the core.
- o_IRQ  out  1  one-cycle request pulse to the controller IRQ input.
- o_ISR_addr  out  5  index of the dispatched source; the controller shifts it by 4.
- o_pending  out  N_SRC  latched pending bits, unmasked view.
- o_busy  out  1  high in any state except IDLE.
- o_chain  out  1  high with o_IRQ when the dispatch is a tail-chain.

Behaviour:
- Reset values:
  - o_IRQ=0, o_ISR_addr=0, o_pending=0, o_busy=0, o_chain=0.
  - mask = all ones; edge register = 0; timeout counter = 0; state = IDLE.
  - A line high at reset release registers an edge on the first cycle after release.
- Edge detect and pending:
  - pend[k] sets when i_src_irq[k]=1 and prev[k]=0; prev is registered each cycle.
  - pend[k] clears in the cycle source k is dispatched (ASSERT).
  - A new edge and a clear on the same bit in the same cycle: set wins.
  - Masked bits stay pending and are dispatched once unmasked.
- Mask: write takes effect the cycle after i_mask_we; it does not affect an interrupt already dispatched.
- Selection: sel = lowest index k with pend[k] & mask[k]; index 0 has highest priority.
- FSM:
  - IDLE: any masked-pending bit → ASSERT.
  - ASSERT (1 cycle):
    - o_IRQ=1; o_ISR_addr=sel, held stable until the next ASSERT.
    - Clear pend[sel]; store sel in act_id; timer=0 → WAIT_ACK.
  - WAIT_ACK:
    - i_in_service=1 → SERVICE.
    - Else timer++; timer==ACK_TIMEOUT → RETRY.
  - RETRY (1 cycle): o_IRQ=1 with o_ISR_addr=act_id, no pending change; timer=0 → WAIT_ACK.
  - SERVICE:
    - i_reti=1 and TAIL_CHAIN=1 and a masked-pending bit exists → ASSERT with o_chain=1 for that pulse; selection is re-evaluated at ASSERT.
    - Otherwise, i_reti=1 or i_in_service falling → IDLE.
- Latency: an edge sampled at cycle t gives o_IRQ at t+2 from IDLE (one cycle to latch pending, one to ASSERT).
- Higher-priority arrivals during SERVICE are never preempted; they stay pending.
- o_busy = (state != IDLE).
- Reset mid-operation: immediate return to IDLE with all pending dropped; o_IRQ low in the cycle after rst.

Test Plan:
- Single source: N_SRC=32, edge on line 5 → o_IRQ pulse 2 cycles later, 1 cycle wide, o_ISR_addr=5, o_pending[5]=0; raise i_in_service → SERVICE; i_reti → IDLE, o_busy=0.
- Priority: edges on lines 9 and 3 in the same cycle → first pulse addr=3, pend[9] stays 1; after reti (TAIL_CHAIN=1) next pulse addr=9 with o_chain=1.
- Mask: mask=~(1<<4), edge on line 4 → no o_IRQ, o_pending[4]=1; write mask all ones → pulse addr=4 two cycles later.
- Timeout: edge on line 7, hold i_in_service=0 → o_IRQ re-pulses with addr=7 every ACK_TIMEOUT+2=17 cycles; assert i_in_service → no further pulses.
- Set/clear collision: new edge on line 2 in the same cycle line 2 is dispatched → o_pending[2]=1 afterwards; second dispatch of 2 after reti.
- Reset mid-service: enter SERVICE on line 1 with line 6 pending, pulse rst → o_busy=0, o_pending=0, no o_IRQ until a new edge arrives.
